// File: rtl/result_out_pkg.sv
// Shared types and default sizing for the result output buffer.
package result_out_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_OUT_W = 5;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/result_out_buf_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer MSB
// separates full from empty.
module sync_fifo
  import result_out_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_wr_en,
  input  logic                         i_rd_en,
  input  logic [WIDTH-1:0]             i_wdata,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_we;
  logic             w_re;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = CW'(r_wr_ptr - r_rd_ptr);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_we = i_wr_en & ~o_full;
  assign w_re = i_rd_en & ~o_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/result_out_buf.sv
// Queues calculation results and serialises each one onto the output
// pins, low beat first, over a valid/ack handshake.
module result_out_buf
  import result_out_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             ans,
  input  logic                         done_calc,
  output logic                         busy,
  output logic [OUT_W-1:0]             out,
  output logic                         out_valid,
  input  logic                         out_ack,
  output logic                         done,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int BEATS = WIDTH / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;
  logic [BW-1:0]    r_beat;
  logic             r_done;
  logic             r_ovf;

  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_shr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_xfer;
  logic             w_last;
  logic             w_fin;
  logic             w_pop;

  assign w_shr  = r_shift >> OUT_W;
  assign w_push = done_calc & ~w_full;
  assign w_xfer = r_valid & out_ack;
  assign w_last = (r_beat == BW'(BEATS-1));
  assign w_fin  = w_xfer & w_last;
  // Pop when idle or when the final beat leaves, so results stream gaplessly
  assign w_pop  = ((r_state == IDLE) | w_fin) & ~w_empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_wr_en (w_push),
    .i_rd_en (w_pop),
    .i_wdata (ans),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_beat  <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (done_calc && w_full) r_ovf <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= SEND;
            r_shift <= w_head;
            r_out   <= w_head[OUT_W-1:0];
            r_beat  <= '0;
            r_valid <= 1'b1;
          end
        end
        SEND: begin
          if (w_xfer) begin
            if (!w_last) begin
              r_shift <= w_shr;
              r_out   <= w_shr[OUT_W-1:0];
              r_beat  <= r_beat + 1'b1;
            end else if (w_pop) begin
              r_shift <= w_head;
              r_out   <= w_head[OUT_W-1:0];
              r_beat  <= '0;
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign busy      = w_full;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign done      = r_done;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_result_out_buf.sv
// Scoreboard bench: default build plus a one-beat-per-result build.
module tb_result_out_buf;

  localparam int W     = 10;
  localparam int OW    = 5;
  localparam int BEATS = W / OW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  ans = '0;
  logic          done_calc = 1'b0;
  logic          out_ack = 1'b0;
  logic          busy;
  logic [OW-1:0] out;
  logic          out_valid;
  logic          done;
  logic          overflow;
  logic [2:0]    count;

  logic [7:0] ans2 = '0;
  logic       dc2 = 1'b0;
  logic       ack2 = 1'b0;
  logic       busy2;
  logic [7:0] out2;
  logic       v2;
  logic       done2;
  logic       ovf2;
  logic [1:0] count2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_done2  = 0;
  int nd0;
  int mbeat    = 0;
  bit fin_prev = 1'b0;
  bit fin_prev2 = 1'b0;
  logic [31:0] q[$];
  logic [31:0] q2[$];

  result_out_buf dut (
    .clock     (clock),
    .reset     (reset),
    .ans       (ans),
    .done_calc (done_calc),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .done      (done),
    .overflow  (overflow),
    .count     (count)
  );

  result_out_buf #(
    .WIDTH (8),
    .OUT_W (8),
    .DEPTH (2)
  ) dut2 (
    .clock     (clock),
    .reset     (reset),
    .ans       (ans2),
    .done_calc (dc2),
    .busy      (busy2),
    .out       (out2),
    .out_valid (v2),
    .out_ack   (ack2),
    .done      (done2),
    .overflow  (ovf2),
    .count     (count2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [31:0] e;
    if (reset) begin
      mbeat    = 0;
      fin_prev = 1'b0;
    end else begin
      check("done", 32'(done), 32'(fin_prev));
      if (done) n_done++;
      fin_prev = 1'b0;
      if (out_valid && out_ack) begin
        if (q.size() != 0) e = q.pop_front();
        else e = 32'hDEAD;
        check("beat", 32'(out), e);
        if (mbeat == BEATS-1) begin
          mbeat    = 0;
          fin_prev = 1'b1;
        end else begin
          mbeat++;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [31:0] e;
    if (reset) begin
      fin_prev2 = 1'b0;
    end else begin
      check("done2", 32'(done2), 32'(fin_prev2));
      if (done2) n_done2++;
      fin_prev2 = 1'b0;
      if (v2 && ack2) begin
        if (q2.size() != 0) e = q2.pop_front();
        else e = 32'hDEAD;
        check("beat2", 32'(out2), e);
        fin_prev2 = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push1(input logic [W-1:0] v, input bit accept);
    logic [W-1:0] t;
    ans       = v;
    done_calc = 1'b1;
    if (accept) begin
      for (int b = 0; b < BEATS; b++) begin
        t = v >> (b * OW);
        q.push_back(32'(t[OW-1:0]));
      end
    end
    tick();
    done_calc = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (q.size() == 0 && !out_valid && count == 0) break;
      tick();
    end
    tick();
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check_cleared("rst");
    check("rst_v2", 32'(v2), 32'd0);
    repeat (3) tick();
    check_cleared("rst_hold");
    reset = 1'b0;
    tick();

    out_ack = 1'b1;
    nd0 = n_done;
    push1(10'h2A5, 1'b1);
    check("lat_v0", 32'(out_valid), 32'd0);
    check("lat_cnt", 32'(count), 32'd1);
    tick();
    check("lat_v1", 32'(out_valid), 32'd1);
    check("lat_b0", 32'(out), 32'h05);
    tick();
    check("lat_b1", 32'(out), 32'h15);
    tick();
    check("end_v", 32'(out_valid), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("idle_out", 32'(out), 32'h15);
    wait_drain(20);
    check("single_ndone", 32'(n_done - nd0), 32'd1);

    out_ack = 1'b0;
    nd0 = n_done;
    push1(10'h2A5, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_out", 32'(out), 32'h05);
      check("bp_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ack = 1'b1;
    wait_drain(20);
    check("bp_ndone", 32'(n_done - nd0), 32'd1);

    out_ack = 1'b0;
    nd0 = n_done;
    for (int i = 1; i <= 5; i++) push1(W'(i), 1'b1);
    check("fill_busy", 32'(busy), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_ovf0", 32'(overflow), 32'd0);
    push1(10'h006, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    out_ack = 1'b1;
    wait_drain(60);
    check("ovf_ndone", 32'(n_done - nd0), 32'd5);
    check("ovf_sticky", 32'(overflow), 32'd1);

    nd0 = n_done;
    push1(10'h3FF, 1'b1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check_cleared("mid_rst");
    q.delete();
    repeat (3) tick();
    check_cleared("mid_hold");
    reset = 1'b0;
    check("mid_ndone", 32'(n_done - nd0), 32'd0);
    tick();
    nd0 = n_done;
    push1(10'h155, 1'b1);
    wait_drain(20);
    check("post_ndone", 32'(n_done - nd0), 32'd1);

    ack2 = 1'b1;
    nd0 = n_done2;
    ans2 = 8'hA1; dc2 = 1'b1; q2.push_back(32'hA1);
    tick();
    ans2 = 8'hB2; q2.push_back(32'hB2);
    tick();
    check("b1_v", 32'(v2), 32'd1);
    check("b1_out0", 32'(out2), 32'hA1);
    ans2 = 8'hC3; q2.push_back(32'hC3);
    tick();
    dc2 = 1'b0;
    check("b1_done0", 32'(done2), 32'd1);
    check("b1_out1", 32'(out2), 32'hB2);
    check("b1_v1", 32'(v2), 32'd1);
    tick();
    check("b1_done1", 32'(done2), 32'd1);
    check("b1_out2", 32'(out2), 32'hC3);
    check("b1_v2", 32'(v2), 32'd1);
    tick();
    check("b1_done2", 32'(done2), 32'd1);
    check("b1_vend", 32'(v2), 32'd0);
    tick();
    check("b1_done3", 32'(done2), 32'd0);
    check("b1_ndone", 32'(n_done2 - nd0), 32'd3);
    check("b1_drain", 32'(q2.size()), 32'd0);
    check("b1_ovf", 32'(ovf2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
